// File: rtl/page_table_responder_if.sv
// Request/response bundle between a TLB (master) and the page table responder
// (slave).
//
// Handshake: busy is the inverse of ready. The master raises req together with
// write_to_table, V_addr_PT_in and P_addr_PT_in. The responder samples them on a
// rising edge only while busy is low. Once busy goes high, the master may change
// or drop any request input without effect. done is a one-cycle pulse. While
// done is high, P_addr_PT_out and page_fault carry the result.
interface page_table_responder_if #(
  parameter int VPN_W = 6,
  parameter int PPN_W = 2
);
  logic             req;
  logic             write_to_table;
  logic [VPN_W-1:0] V_addr_PT_in;
  logic [PPN_W-1:0] P_addr_PT_in;
  logic             busy;
  logic             done;
  logic [PPN_W-1:0] P_addr_PT_out;
  logic             page_fault;

  modport master (
    output req,
    output write_to_table,
    output V_addr_PT_in,
    output P_addr_PT_in,
    input  busy,
    input  done,
    input  P_addr_PT_out,
    input  page_fault
  );

  modport slave (
    input  req,
    input  write_to_table,
    input  V_addr_PT_in,
    input  P_addr_PT_in,
    output busy,
    output done,
    output P_addr_PT_out,
    output page_fault
  );
endinterface

// File: rtl/page_table_responder.sv
// page_table_responder: a fixed-latency page table behind a TLB.
// The table holds 2^VPN_W entries of {valid, PPN}. A request is accepted in
// IDLE and waits ACCESS_LATENCY edges in ACCESS. On the last of those edges it
// performs the table operation and moves to RESP. RESP raises done for one
// cycle.
// Optional feature: define PT_AUTO_ALLOC_EN so that a lookup of an invalid
// entry allocates the next PPN from a wrapping pointer instead of faulting.
module page_table_responder #(
  parameter int ACCESS_LATENCY = 3,
  parameter int VPN_W          = 6,
  parameter int PPN_W          = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  page_table_responder_if.slave pt,
  output logic [1:0]           state_dbg_o
);

  localparam int DEPTH = 1 << VPN_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Control state
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  // Latched request; later input changes must not disturb an accepted request
  logic             wr_q, wr_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [PPN_W-1:0] ppn_in_q, ppn_in_d;

  // Table storage
  logic [DEPTH-1:0] valid_q;
  logic [PPN_W-1:0] ppn_tab_q [DEPTH];

  // Response registers
  logic [PPN_W-1:0] out_q, out_d;
  logic             fault_q, fault_d;

  // Decoded table operation
  logic             accept;
  logic             op_fire;
  logic             entry_valid;
  logic [PPN_W-1:0] entry_ppn;
  logic             tab_we;
  logic [PPN_W-1:0] tab_wdata;
  logic [PPN_W-1:0] res_ppn;
  logic             res_fault;

`ifdef PT_AUTO_ALLOC_EN
  logic [PPN_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic             alloc_adv;
`endif

  assign accept      = (state_q == S_IDLE) && pt.req;
  assign op_fire     = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign entry_valid = valid_q[vpn_q];
  assign entry_ppn   = ppn_tab_q[vpn_q];

  // Next-state and latency counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pt.req) begin
          state_d = S_ACCESS;
          cnt_d   = 4'(ACCESS_LATENCY - 1);
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // No accept here: the next request waits for IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Request latch: capture the operands only when a request is accepted
  always_comb begin
    wr_d     = wr_q;
    vpn_d    = vpn_q;
    ppn_in_d = ppn_in_q;
    if (accept) begin
      wr_d     = pt.write_to_table;
      vpn_d    = pt.V_addr_PT_in;
      ppn_in_d = pt.P_addr_PT_in;
    end
  end

  // Table operation: write-back, lookup hit, and lookup miss (fault or allocate)
  always_comb begin
    tab_we    = 1'b0;
    tab_wdata = ppn_in_q;
    res_ppn   = '0;
    res_fault = 1'b0;
`ifdef PT_AUTO_ALLOC_EN
    alloc_adv = 1'b0;
`endif
    if (wr_q) begin
      tab_we    = 1'b1;
      tab_wdata = ppn_in_q;
    end else if (entry_valid) begin
      res_ppn = entry_ppn;
    end else begin
`ifdef PT_AUTO_ALLOC_EN
      tab_we    = 1'b1;
      tab_wdata = alloc_ptr_q;
      res_ppn   = alloc_ptr_q;
      alloc_adv = 1'b1;
`else
      res_fault = 1'b1;
`endif
    end
  end

  // The response registers load on the operation edge and hold outside it
  always_comb begin
    out_d   = out_q;
    fault_d = fault_q;
    if (op_fire) begin
      out_d   = res_ppn;
      fault_d = res_fault;
    end
  end

`ifdef PT_AUTO_ALLOC_EN
  // The allocation pointer wraps naturally at 2^PPN_W
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    if (op_fire && alloc_adv) begin
      alloc_ptr_d = alloc_ptr_q + PPN_W'(1);
    end
  end

  // Allocation pointer register
  always_ff @(posedge clock) begin
    if (reset) begin
      alloc_ptr_q <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
    end
  end
`endif

  // FSM and counter registers; reset aborts any operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request operands
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q     <= 1'b0;
      vpn_q    <= '0;
      ppn_in_q <= '0;
    end else begin
      wr_q     <= wr_d;
      vpn_q    <= vpn_d;
      ppn_in_q <= ppn_in_d;
    end
  end

  // Page table storage; reset invalidates and zeroes every entry
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ppn_tab_q[i] <= '0;
      end
    end else if (op_fire && tab_we) begin
      valid_q[vpn_q]   <= 1'b1;
      ppn_tab_q[vpn_q] <= tab_wdata;
    end
  end

  // Response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      fault_q <= fault_d;
    end
  end

  assign pt.busy          = (state_q != S_IDLE);
  assign pt.done          = (state_q == S_RESP);
  assign pt.P_addr_PT_out = out_q;
  assign pt.page_fault    = (state_q == S_RESP) && fault_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_page_table_responder.sv
// Directed bench for page_table_responder (ACCESS_LATENCY=3, VPN_W=6, PPN_W=2).
// Define PT_AUTO_ALLOC_EN for both bench and RTL to exercise the
// allocate-on-miss build.
module tb_page_table_responder;

  localparam int LAT = 3;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  page_table_responder_if #(.VPN_W(6), .PPN_W(2)) bus ();

  page_table_responder #(
    .ACCESS_LATENCY(LAT),
    .VPN_W(6),
    .PPN_W(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pt         (bus.slave),
    .state_dbg_o(state_dbg)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request issued from an idle negedge. Afterwards the bench checks the
  // latency, the result, the one-cycle done pulse and the held output.
  task automatic do_req(input logic wr, input logic [5:0] vpn, input logic [1:0] ppn,
                        input logic [1:0] exp_ppn, input logic exp_pf, input string tag);
    int cyc;
    bit seen;
    bus.req            = 1'b1;
    bus.write_to_table = wr;
    bus.V_addr_PT_in   = vpn;
    bus.P_addr_PT_in   = ppn;
    @(negedge clock);
    // Changing the inputs after the accept edge must have no effect.
    bus.req            = 1'b0;
    bus.write_to_table = 1'($urandom_range(0, 1));
    bus.V_addr_PT_in   = 6'($urandom_range(0, 63));
    bus.P_addr_PT_in   = 2'($urandom_range(0, 3));
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    chk({tag, "_latency"}, seen ? cyc : 0, LAT + 1);
    chk({tag, "_ppn"}, {30'd0, bus.P_addr_PT_out}, {30'd0, exp_ppn});
    chk({tag, "_pf"}, {31'd0, bus.page_fault}, {31'd0, exp_pf});
    @(negedge clock);
    chk({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_pf_low"}, {31'd0, bus.page_fault}, 32'd0);
    chk({tag, "_ppn_hold"}, {30'd0, bus.P_addr_PT_out}, {30'd0, exp_ppn});
  endtask

  initial begin
    reset              = 1'b1;
    bus.req            = 1'b0;
    bus.write_to_table = 1'b0;
    bus.V_addr_PT_in   = '0;
    bus.P_addr_PT_in   = '0;

    // Reset values
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ppn", {30'd0, bus.P_addr_PT_out}, 32'd0);
    chk("rst_pf", {31'd0, bus.page_fault}, 32'd0);
    @(negedge clock);

`ifdef PT_AUTO_ALLOC_EN
    // Allocate on miss: 0,1,2,3 then wrap to 0; a re-lookup returns the stored PPN
    do_req(1'b0, 6'd1, 2'd0, 2'd0, 1'b0, "alloc_v1");
    do_req(1'b0, 6'd2, 2'd0, 2'd1, 1'b0, "alloc_v2");
    do_req(1'b0, 6'd3, 2'd0, 2'd2, 1'b0, "alloc_v3");
    do_req(1'b0, 6'd4, 2'd0, 2'd3, 1'b0, "alloc_v4");
    do_req(1'b0, 6'd5, 2'd0, 2'd0, 1'b0, "alloc_v5_wrap");
    do_req(1'b0, 6'd1, 2'd0, 2'd0, 1'b0, "relookup_v1");
    do_req(1'b0, 6'd4, 2'd0, 2'd3, 1'b0, "relookup_v4");
    // A write-back followed by a lookup returns the written PPN
    do_req(1'b1, 6'h2A, 2'd3, 2'd0, 1'b0, "wr_2a");
    do_req(1'b0, 6'h2A, 2'd0, 2'd3, 1'b0, "rd_2a");
    // Reset clears the table and the pointer, so the next miss allocates 0 again
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    do_req(1'b0, 6'd9, 2'd0, 2'd0, 1'b0, "alloc_after_rst");
    do_req(1'b0, 6'd10, 2'd0, 2'd1, 1'b0, "alloc_after_rst2");
`else
    // Lookup of an unmapped entry faults
    do_req(1'b0, 6'd5, 2'd0, 2'd0, 1'b1, "miss_v5");

    // Write-back followed by a lookup of the same VPN
    do_req(1'b1, 6'h2A, 2'd3, 2'd0, 1'b0, "wr_2a");
    do_req(1'b0, 6'h2A, 2'd0, 2'd3, 1'b0, "rd_2a");

    // Inputs that change after the accept edge are not written
    do_req(1'b1, 6'h10, 2'd1, 2'd0, 1'b0, "wr_10");
    do_req(1'b0, 6'h10, 2'd0, 2'd1, 1'b0, "rd_10");
    do_req(1'b0, 6'h11, 2'd0, 2'd0, 1'b1, "miss_11");
    do_req(1'b1, 6'h3F, 2'd2, 2'd0, 1'b0, "wr_3f");
    do_req(1'b0, 6'h3F, 2'd0, 2'd2, 1'b0, "rd_3f");

    // req held high: one accept every LAT+2 edges
    bus.req            = 1'b1;
    bus.write_to_table = 1'b0;
    bus.V_addr_PT_in   = 6'h2A;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      chk($sformatf("held_busy_%0d", i), {31'd0, bus.busy}, (i % 5 != 0) ? 32'd1 : 32'd0);
      chk($sformatf("held_done_%0d", i), {31'd0, bus.done}, (i % 5 == 4) ? 32'd1 : 32'd0);
      if (i % 5 == 4) chk($sformatf("held_ppn_%0d", i), {30'd0, bus.P_addr_PT_out}, 32'd3);
    end
    bus.req = 1'b0;
    @(negedge clock);
    chk("held_stop_busy", {31'd0, bus.busy}, 32'd0);

    // Reset during ACCESS of a write aborts it
    bus.req            = 1'b1;
    bus.write_to_table = 1'b1;
    bus.V_addr_PT_in   = 6'd7;
    bus.P_addr_PT_in   = 2'd2;
    @(negedge clock);
    bus.req = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abort_nodone_%0d", i), {31'd0, bus.done}, 32'd0);
      @(negedge clock);
    end
    do_req(1'b0, 6'd7, 2'd0, 2'd0, 1'b1, "abort_rd_v7");
    do_req(1'b0, 6'h2A, 2'd0, 2'd0, 1'b1, "rst_cleared_2a");

    // Reset wins over a simultaneous req
    reset   = 1'b1;
    bus.req = 1'b1;
    @(negedge clock);
    chk("rst_prio_busy", {31'd0, bus.busy}, 32'd0);
    reset   = 1'b0;
    bus.req = 1'b0;
    @(negedge clock);
    chk("rst_prio_idle", {31'd0, bus.busy}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/page_table_responder.md
PAGE_TABLE_RESPONDER -- requirements
Module: page_table_responder

Interface
REQ-001 Parameter ACCESS_LATENCY, default 3, rising edges from request accept to done; legal range 1..15.
REQ-002 Parameter VPN_W, default 6, virtual page number width (64 entries).
REQ-003 Parameter PPN_W, default 2, physical page number width.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  TLB request strobe, sampled only in IDLE.
REQ-007 write_to_table  input  1  1 = write-back of evicted entry, 0 = lookup.
REQ-008 V_addr_PT_in  input  VPN_W  VPN to read or write.
REQ-009 P_addr_PT_in  input  PPN_W  PPN to store on write.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse to TLB.
REQ-012 P_addr_PT_out  output  PPN_W  PPN returned for a lookup, valid while done is high.
REQ-013 page_fault  output  1  lookup hit an invalid entry, valid while done is high.

Function
REQ-014 Storage: 2^VPN_W entries of {valid, PPN}, indexed by VPN.
REQ-015 FSM states: IDLE, ACCESS, RESP; encoding is free.
REQ-016 IDLE: req=1 at an edge -> latch write_to_table, V_addr_PT_in and P_addr_PT_in; load the latency counter with ACCESS_LATENCY-1; go to ACCESS.
REQ-017 ACCESS: decrement the counter each edge; at counter 0, perform the table operation and go to RESP on that same edge.
REQ-018 Latency: a request accepted at edge k makes done high during the cycle after edge k+ACCESS_LATENCY, for exactly one cycle.
REQ-019 RESP: done=1; next edge -> IDLE unconditionally. req is not accepted in RESP.
REQ-020 Requests presented in ACCESS or RESP are ignored, not queued; inputs may change after accept without effect.
REQ-021 Write op: entry[VPN] <= {valid=1, PPN}; P_addr_PT_out=0 and page_fault=0 during done.
REQ-022 Lookup, valid entry: P_addr_PT_out = entry PPN, page_fault=0.
REQ-023 Lookup, invalid entry: behaviour per REQ-031/REQ-032.
REQ-024 Outside RESP: done=0, page_fault=0, P_addr_PT_out holds its last value.
REQ-025 Back-to-back: the earliest next accept is the edge ending RESP+1 (IDLE); minimum request spacing is ACCESS_LATENCY+2 edges.
REQ-026 A write followed by a lookup of the same VPN returns the written PPN.

Reset
REQ-027 reset=1 at an edge: state <= IDLE, counter <= 0, all entries valid <= 0 (PPN <= 0).
REQ-028 Output values after reset: busy=0, done=0, P_addr_PT_out=0, page_fault=0.
REQ-029 Reset during ACCESS or RESP aborts the operation: no table write, no done pulse.
REQ-030 Reset has priority over req in the same cycle.

Configuration
REQ-031 Macro PT_AUTO_ALLOC_EN defined: a lookup of an invalid entry allocates PPN = alloc_ptr, writes {1, alloc_ptr} to the entry, and returns it with page_fault=0. alloc_ptr is PPN_W bits wide, reset to 0, and increments on each allocation, wrapping modulo 2^PPN_W.
REQ-032 Macro PT_AUTO_ALLOC_EN undefined: a lookup of an invalid entry returns P_addr_PT_out=0 and page_fault=1, with the table unchanged; alloc_ptr logic is absent.

Verification
REQ-033 Reset, then lookup VPN 5 with the macro undefined -> done pulse 4 cycles after accept, page_fault=1, P_addr_PT_out=0.
REQ-034 Write VPN 0x2A, PPN 3, then lookup 0x2A -> second done has P_addr_PT_out=3, page_fault=0.
REQ-035 req held high continuously -> one accept every 5 edges (ACCESS_LATENCY=3); busy high 4 of every 5 cycles; no extra done pulses.
REQ-036 reset asserted during ACCESS of a write to VPN 7, PPN 2 -> no done; a later lookup of VPN 7 faults (macro undefined).
REQ-037 Macro defined: lookups of unmapped VPNs 1, 2, 3, 4, 5 -> PPN 0, 1, 2, 3, 0, page_fault=0; a re-lookup of VPN 1 returns 0.
